// File: rtl/pin_checker_pkg.sv
// Shared definitions for the pin pattern checker.
// FSM state encoding, pattern count and settle counter width.
package pin_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int N_PATTERNS = 4;
   localparam int CNT_W      = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous pin input.
// No reset: the first two samples after power-up are don't-care.
module sync_2ff (
   input  logic clk,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // shift the pin level through two flops
   always_ff @(posedge clk) begin
      r_meta <= i_d;
      r_sync <= r_meta;
   end

   assign o_q = r_sync;

endmodule

// File: rtl/pin_pattern_checker.sv
// Self-test sequencer for the two-input OR path: drives all four
// input patterns, samples the synchronized response, scores results.
module pin_pattern_checker
   import pin_checker_pkg::*;
#(
   parameter int         SETTLE_CYCLES = 4,
   parameter logic [3:0] EXPECT        = 4'b1110
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       resp_i,
   output logic [1:0] drive_o,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [3:0] fail_vec
);

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 2);
   localparam logic [1:0]       PAT_LAST    = 2'(N_PATTERNS - 1);

   state_t             r_state;
   logic [1:0]         r_pat;
   logic [CNT_W-1:0]   r_cnt;
   logic [2:0]         r_err;
   logic [3:0]         r_fail;

   state_t             w_state_nxt;
   logic [1:0]         w_pat_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [2:0]         w_err_nxt;
   logic [3:0]         w_fail_nxt;
   logic               w_resp_s;
   logic               w_mismatch;

   sync_2ff u_sync (
      .clk (clk),
      .i_d (resp_i),
      .o_q (w_resp_s)
   );

   // state, pattern, settle counter and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_pat   <= 2'd0;
         r_cnt   <= '0;
         r_err   <= 3'd0;
         r_fail  <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_pat   <= w_pat_nxt;
         r_cnt   <= w_cnt_nxt;
         r_err   <= w_err_nxt;
         r_fail  <= w_fail_nxt;
      end
   end

   assign w_mismatch = (w_resp_s != EXPECT[r_pat]);

   // next-state: sequence patterns, settle, then score one sample each
   always_comb begin
      w_state_nxt = r_state;
      w_pat_nxt   = r_pat;
      w_cnt_nxt   = r_cnt;
      w_err_nxt   = r_err;
      w_fail_nxt  = r_fail;
      unique case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_state_nxt = ST_HOLD;
               w_pat_nxt   = 2'd0;
               w_cnt_nxt   = '0;
               w_err_nxt   = 3'd0;
               w_fail_nxt  = 4'd0;
            end
         end
         ST_HOLD: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == SETTLE_LAST) begin
               w_state_nxt = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (w_mismatch) begin
               w_fail_nxt[r_pat] = 1'b1;
               w_err_nxt         = r_err + 3'd1;
            end
            if (r_pat == PAT_LAST) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_HOLD;
               w_pat_nxt   = r_pat + 2'd1;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign busy      = (r_state == ST_HOLD) || (r_state == ST_CHECK);
   assign done      = (r_state == ST_DONE);
   assign pass      = done && (r_err == 3'd0);
   assign drive_o   = busy ? r_pat : 2'b00;
   assign err_count = r_err;
   assign fail_vec  = r_fail;

endmodule
